// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver with output FIFO.
//
// Contents:
//   UART_DATA_BITS       - payload bits per frame (8)
//   CLKS_PER_BIT_DEFAULT - default bit period in clk cycles (100 MHz / 115200)
//   uart_state_e         - receiver FSM state encoding
//   even_parity()        - parity bit that makes the total count of ones even
//
// Build option: UART_RX_PARITY_EN adds the StParity state (8E1 frames).
package uart_pkg;

    localparam int unsigned UART_DATA_BITS       = 8;
    localparam int unsigned CLKS_PER_BIT_DEFAULT = 868;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_RX_PARITY_EN
        StParity,
`endif
        StStop,
        StWaitIdle
    } uart_state_e;

    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Byte stream handshake between the UART receiver FIFO and its consumer.
//
// Signals:
//   out_data  - head byte of the receive FIFO
//   out_valid - FIFO holds at least one byte
//   out_ready - consumer accepts the head byte this cycle
//
// Modports: master (receiver side), slave (consumer side).
interface uart_rx_fifo_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] out_data;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with power-of-two depth.
//
// Parameters:
//   Width - entry width in bits
//   Depth - number of entries, power of two, at least 2
//
// Ports:
//   clk_i, rst_ni - clock, asynchronous active-low reset
//   push_i        - write data_i; accepted when not full, or when full with a pop
//   data_i        - write data
//   pop_i         - remove the head entry (ignored when empty)
//   data_o        - head entry, stable until popped
//   empty_o       - no entries stored
//   full_o        - Depth entries stored
module sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [AddrW:0] PtrOne = {{AddrW{1'b0}}, 1'b1};

    // Pointers carry one extra bit so that full and empty differ only in the MSB.
    logic [AddrW:0]   wr_ptr_q, wr_ptr_d;
    logic [AddrW:0]   rd_ptr_q, rd_ptr_d;
    logic [Width-1:0] mem_q [Depth];
    logic             wr_en;
    logic             rd_en;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                     (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);

    // When full, the write slot equals the head slot; a simultaneous pop frees it.
    assign wr_en = push_i && (!full_o || pop_i);
    assign rd_en = pop_i && !empty_o;

    assign data_o = mem_q[rd_ptr_q[AddrW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is cleared on reset so the head output reads zero while empty.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_ptr_q[AddrW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN) feeding a byte FIFO.
//
// Parameters:
//   CLKS_PER_BIT - clk cycles per UART bit, 4..65535
//   FIFO_DEPTH   - receive FIFO entries, power of two, 2..16
//
// Ports:
//   clk         - system clock
//   rst_n       - asynchronous active-low reset
//   uart_rx     - asynchronous serial input, idle high
//   out_if      - byte stream to the consumer (out_data/out_valid/out_ready)
//   framing_err - one-cycle pulse: stop bit sampled low, byte dropped
//   overrun_err - one-cycle pulse: good byte dropped, FIFO full
//   parity_err  - one-cycle pulse: even parity mismatch, byte dropped
//                 (constant 0 unless UART_RX_PARITY_EN is defined)
//
// Build option: UART_RX_PARITY_EN inserts a parity bit between data and stop.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           uart_rx,
    uart_rx_fifo_if.master out_if,
    output logic           framing_err,
    output logic           overrun_err,
    output logic           parity_err
);

    localparam int unsigned CntW = 16;
    localparam logic [CntW-1:0] CntOne   = {{(CntW-1){1'b0}}, 1'b1};
    localparam logic [CntW-1:0] HalfBit  = CntW'(CLKS_PER_BIT / 2);
    localparam logic [CntW-1:0] FullBit  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]      LastBit  = 3'(UART_DATA_BITS - 1);

    // Two-flop synchronizer; resets to the idle line level.
    logic [1:0] sync_q;
    logic       rx_s;
    logic       rx_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[0], uart_rx};
            rx_prev_q <= sync_q[1];
        end
    end

    assign rx_s = sync_q[1];

    uart_state_e               state_q;
    logic [CntW-1:0]           cnt_q;
    logic [2:0]                bit_idx_q;
    logic [UART_DATA_BITS-1:0] shift_q;
`ifdef UART_RX_PARITY_EN
    logic                      par_bad_q;
`endif

    logic fifo_empty;
    logic fifo_full;
    logic stop_sample;
    logic push;
    logic pop;

    // The push strobe is taken straight from the stop-bit sample so the FIFO
    // writes on the closing edge of that cycle and out_valid follows one cycle later.
    assign stop_sample = (state_q == StStop) && (cnt_q == '0);
`ifdef UART_RX_PARITY_EN
    assign push = stop_sample && rx_s && !par_bad_q;
`else
    assign push = stop_sample && rx_s;
`endif
    assign pop = out_if.out_valid && out_if.out_ready;

    assign out_if.out_valid = !fifo_empty;

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            framing_err <= 1'b0;
            overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q   <= 1'b0;
            parity_err  <= 1'b0;
`endif
        end else begin
            framing_err <= 1'b0;
            overrun_err <= push && fifo_full && !pop;
`ifdef UART_RX_PARITY_EN
            parity_err  <= 1'b0;
`endif
            case (state_q)
                StIdle: begin
                    if (rx_prev_q && !rx_s) begin
                        state_q <= StStart;
                        cnt_q   <= HalfBit;
                    end
                end
                StStart: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CntOne;
                    end else if (!rx_s) begin
                        state_q   <= StData;
                        cnt_q     <= FullBit;
                        bit_idx_q <= '0;
                    end else begin
                        // Line went back high before mid start bit: a glitch.
                        state_q <= StIdle;
                    end
                end
                StData: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CntOne;
                    end else begin
                        shift_q <= {rx_s, shift_q[UART_DATA_BITS-1:1]};
                        cnt_q   <= FullBit;
                        if (bit_idx_q == LastBit) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= StParity;
`else
                            state_q <= StStop;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                StParity: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CntOne;
                    end else begin
                        par_bad_q <= (even_parity(shift_q) != rx_s);
                        cnt_q     <= FullBit;
                        state_q   <= StStop;
                    end
                end
`endif
                StStop: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CntOne;
                    end else if (!rx_s) begin
                        // Framing wins over parity so only one error fires per frame.
                        framing_err <= 1'b1;
                        state_q     <= StWaitIdle;
                    end else begin
`ifdef UART_RX_PARITY_EN
                        parity_err  <= par_bad_q;
`endif
                        state_q     <= StIdle;
                    end
                end
                StWaitIdle: begin
                    // Hold here through a break; a fresh start needs the line high first.
                    if (rx_s) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    sync_fifo #(
        .Width(UART_DATA_BITS),
        .Depth(FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .push_i (push),
        .data_i (shift_q),
        .pop_i  (pop),
        .data_o (out_if.out_data),
        .empty_o(fifo_empty),
        .full_o (fifo_full)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at CLKS_PER_BIT=16, FIFO_DEPTH=4.
// Delivered bytes are logged by a monitor and compared against a scoreboard
// of bytes expected at the time each frame is driven.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int unsigned CPB   = 16;
    localparam int unsigned DEPTH = 4;
    // Cycles from the edge that launches the start bit to out_valid high:
    // 2 sync + 1 edge detect + (CPB/2 + 1) start + 8 data bits + stop sample.
`ifdef UART_RX_PARITY_EN
    localparam int unsigned LAT = 3 + CPB / 2 + 1 + 10 * CPB;
`else
    localparam int unsigned LAT = 3 + CPB / 2 + 1 + 9 * CPB;
`endif

    logic clk;
    logic rst_n;
    logic uart_rx;
    logic framing_err;
    logic overrun_err;
    logic parity_err;

    uart_rx_fifo_if u_if ();

    uart_rx_fifo #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_rx    (uart_rx),
        .out_if     (u_if.master),
        .framing_err(framing_err),
        .overrun_err(overrun_err),
        .parity_err (parity_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0;
    int oe_cnt = 0;
    int pe_cnt = 0;
    int got_rd = 0;
    logic [7:0] got_q [$];
    logic [7:0] sb_q  [$];

    // Monitor: log accepted bytes and count error-pulse cycles.
    always @(negedge clk) begin
        if (rst_n) begin
            if (u_if.out_valid && u_if.out_ready) got_q.push_back(u_if.out_data);
            if (framing_err) fe_cnt++;
            if (overrun_err) oe_cnt++;
            if (parity_err)  pe_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bit_out(input logic b);
        uart_rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic stop_b, input logic flip_par);
        @(posedge clk);
        #1;
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(d[i]);
`ifdef UART_RX_PARITY_EN
        bit_out((^d) ^ flip_par);
`else
        if (flip_par) $display("note: parity flip has no effect in the 8N1 build");
`endif
        bit_out(stop_b);
    endtask

    // Compare every newly delivered byte against the scoreboard head.
    task automatic compare_outputs();
        logic [7:0] exp;
        while (got_rd < got_q.size()) begin
            chk("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                exp = sb_q.pop_front();
                chk("out_data", 32'(got_q[got_rd]), 32'(exp));
            end
            got_rd++;
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        uart_rx       = 1'b1;
        u_if.out_ready = 1'b0;
        rst_n         = 1'b0;
        wait_cycles(3);
        chk("rst_valid", 32'(u_if.out_valid), 32'd0);
        chk("rst_data", 32'(u_if.out_data), 32'd0);
        chk("rst_errs", 32'({framing_err, overrun_err, parity_err}), 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'(StIdle));
        rst_n = 1'b1;
        wait_cycles(5);

        // Single byte, consumer ready, exact push-to-valid latency.
        u_if.out_ready = 1'b1;
        sb_q.push_back(8'hA5);
        fork
            drive_frame(8'hA5, 1'b1, 1'b0);
            begin
                @(posedge clk);
                repeat (LAT - 1) @(posedge clk);
                #2;
                chk("a5_valid_before", 32'(u_if.out_valid), 32'd0);
                @(posedge clk);
                #2;
                chk("a5_valid_at", 32'(u_if.out_valid), 32'd1);
                chk("a5_data_at", 32'(u_if.out_data), 32'hA5);
            end
        join
        wait_cycles(20);
        compare_outputs();
        chk("a5_no_errs", 32'(fe_cnt + oe_cnt + pe_cnt), 32'd0);

        // Fill the FIFO with the consumer stalled; fifth byte overruns.
        u_if.out_ready = 1'b0;
        sb_q.push_back(8'h3C);
        drive_frame(8'h3C, 1'b1, 1'b0);
        sb_q.push_back(8'h81);
        drive_frame(8'h81, 1'b1, 1'b0);
        sb_q.push_back(8'hFF);
        drive_frame(8'hFF, 1'b1, 1'b0);
        sb_q.push_back(8'h00);
        drive_frame(8'h00, 1'b1, 1'b0);
        drive_frame(8'h55, 1'b1, 1'b0);
        wait_cycles(20);
        chk("ovr_pulse", 32'(oe_cnt), 32'd1);
        chk("ovr_no_fe", 32'(fe_cnt), 32'd0);
        chk("full_valid", 32'(u_if.out_valid), 32'd1);
        chk("full_head", 32'(u_if.out_data), 32'h3C);
        wait_cycles(10);
        chk("stall_head_stable", 32'(u_if.out_data), 32'h3C);
        chk("stall_no_pop", 32'(got_q.size()), 32'd1);
        u_if.out_ready = 1'b1;
        wait_cycles(10);
        chk("drain_count", 32'(got_q.size()), 32'd5);
        compare_outputs();
        chk("drained_valid", 32'(u_if.out_valid), 32'd0);

        // Stop bit low: framing error, byte dropped, held until line high.
        drive_frame(8'h42, 1'b0, 1'b0);
        wait_cycles(30);
        chk("fe_pulse", 32'(fe_cnt), 32'd1);
        chk("fe_wait_idle", 32'(dut.state_q), 32'(StWaitIdle));
        chk("fe_no_push", 32'(u_if.out_valid), 32'd0);
        uart_rx = 1'b1;
        wait_cycles(5);
        chk("fe_back_idle", 32'(dut.state_q), 32'(StIdle));
        sb_q.push_back(8'h5A);
        drive_frame(8'h5A, 1'b1, 1'b0);
        wait_cycles(20);
        compare_outputs();
        chk("after_fe_count", 32'(got_q.size()), 32'd6);

        // Short low glitch is rejected silently.
        uart_rx = 1'b0;
        wait_cycles(4);
        uart_rx = 1'b1;
        wait_cycles(30);
        chk("glitch_idle", 32'(dut.state_q), 32'(StIdle));
        chk("glitch_no_push", 32'(got_q.size()), 32'd6);
        chk("glitch_errs", 32'(fe_cnt + oe_cnt + pe_cnt), 32'd2);

        // Reset mid-frame clears FIFO and partial byte.
        u_if.out_ready = 1'b0;
        sb_q.push_back(8'h6E);
        drive_frame(8'h6E, 1'b1, 1'b0);
        wait_cycles(5);
        chk("pre_rst_head", 32'(u_if.out_data), 32'h6E);
        fork
            drive_frame(8'h99, 1'b1, 1'b0);
            begin
                @(posedge clk);
                repeat (4 * CPB + CPB / 2) @(posedge clk);
                #1;
                rst_n = 1'b0;
                #2;
                chk("midrst_valid", 32'(u_if.out_valid), 32'd0);
                chk("midrst_data", 32'(u_if.out_data), 32'd0);
                chk("midrst_state", 32'(dut.state_q), 32'(StIdle));
            end
        join
        sb_q.delete();
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(5);
        u_if.out_ready = 1'b1;
        sb_q.push_back(8'h17);
        drive_frame(8'h17, 1'b1, 1'b0);
        wait_cycles(20);
        chk("post_rst_count", 32'(got_q.size()), 32'd7);
        compare_outputs();

`ifdef UART_RX_PARITY_EN
        // Wrong parity drops the byte; correct parity delivers it.
        drive_frame(8'h07, 1'b1, 1'b1);
        wait_cycles(20);
        chk("par_pulse", 32'(pe_cnt), 32'd1);
        chk("par_dropped", 32'(got_q.size()), 32'd7);
        sb_q.push_back(8'h07);
        drive_frame(8'h07, 1'b1, 1'b0);
        wait_cycles(20);
        chk("par_ok_count", 32'(got_q.size()), 32'd8);
        chk("par_ok_no_pulse", 32'(pe_cnt), 32'd1);
        compare_outputs();
`endif

        chk("final_fe", 32'(fe_cnt), 32'd1);
        chk("final_oe", 32'(oe_cnt), 32'd1);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        chk("all_compared", 32'(got_rd), 32'(got_q.size()));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
